// File: rtl/main_memory_pkg.sv
// Shared constants and reset-pattern helper for the cache backing store.
// MEM_INIT_PATTERN_EN selects a word-index reset pattern instead of all-zero.
package main_memory_pkg;

  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 64;
  localparam int BLOCK_OFS_W = 3;
  localparam int DEPTH       = 2 ** (ADDR_W - BLOCK_OFS_W);
  localparam int WORD_W      = 32;

`ifdef MEM_INIT_PATTERN_EN
  localparam logic PATTERN_EN = 1'b1;
`else
  localparam logic PATTERN_EN = 1'b0;
`endif

  // Each 32-bit word holds its own word index (byte address >> 2) when enabled.
  function automatic logic [DATA_W-1:0] init_block(input int unsigned index);
    logic [DATA_W-1:0] pattern;
    pattern = {WORD_W'(2 * index + 1), WORD_W'(2 * index)};
    return PATTERN_EN ? pattern : '0;
  endfunction

endpackage

// File: rtl/main_memory_bank.sv
// 128 x 64-bit block store with combinational read and synchronous write.
// Reset contents come from init_block(), which honours MEM_INIT_PATTERN_EN.
module main_memory_bank
  import main_memory_pkg::*;
#(
  parameter int ADDR_W = main_memory_pkg::ADDR_W,
  parameter int DATA_W = main_memory_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data
);

  localparam int BLK_W = ADDR_W - BLOCK_OFS_W;
  localparam int DEPTH = 2 ** BLK_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [BLK_W-1:0]  blk_idx;
  logic              unused_ofs;

  // Byte offset within a block never selects anything; whole blocks only.
  assign blk_idx    = mem_address[ADDR_W-1:BLOCK_OFS_W];
  assign unused_ofs = ^mem_address[BLOCK_OFS_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i[BLK_W-1:0]] <= init_block(i);
      end
    end else if (mem_write) begin
      mem[blk_idx] <= mem_write_data;
    end
  end

  // No bypass: a same-block write becomes visible only after the edge.
  assign mem_read_data = mem[blk_idx];

endmodule

// File: tb/tb_main_memory_bank.sv
// Randomized scoreboard bench for main_memory_bank against an array model.
module tb_main_memory_bank;

  logic        clk;
  logic        rst;
  logic        mem_write;
  logic [9:0]  mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  main_memory_bank dut (
    .clk           (clk),
    .rst           (rst),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } sb_item_t;

  sb_item_t    sb[$];
  event        chk_ev;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] ref_mem [128];

  always @(posedge clk) begin
    if (!rst) assert (!$isunknown(mem_write)) else $error("mem_write is X outside reset");
  end

  // Reset value derived from word addressing: word n of the space holds n.
  function automatic logic [63:0] reset_value(input int blk);
    int unsigned w0, w1;
    w0 = (blk * 8) / 4;
    w1 = (blk * 8 + 4) / 4;
`ifdef MEM_INIT_PATTERN_EN
    return {w1, w0};
`else
    if (w0 == w1) return 64'h1;
    return 64'h0;
`endif
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 128; b++) ref_mem[b] = reset_value(b);
  endtask

  // Monitor: compares the DUT output whenever the stimulus side posts expectations.
  initial begin
    forever begin
      @(chk_ev);
      #1;
      while (sb.size() > 0) begin
        sb_item_t it;
        it = sb.pop_front();
        checks++;
        if (mem_read_data !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, mem_read_data, it.exp);
        end
      end
    end
  end

  task automatic check_read(input logic [9:0] addr, input string name);
    sb_item_t it;
    mem_address = addr;
    it.name = name;
    it.exp  = ref_mem[addr / 8];
    sb.push_back(it);
    -> chk_ev;
    for (int k = 0; k < 5 && sb.size() != 0; k++) #1;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL %s: monitor timeout, %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Drive a write from a falling edge, commit it in the model at the rising edge.
  task automatic do_write(input logic [9:0] addr, input logic [63:0] data);
    @(negedge clk);
    mem_write      = 1'b1;
    mem_address    = addr;
    mem_write_data = data;
    @(posedge clk);
    if (!rst) ref_mem[addr / 8] = data;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_read(10'h028, "reset_during_blk5");
    @(negedge clk);
    rst = 1'b0;
    check_read(10'h028, "reset_after_blk5");
    @(negedge clk);
    check_read(10'h3FF, "reset_after_blk127");

    do_write(10'h3F8, 64'hDEADBEEF_CAFEF00D);
    check_read(10'h3F8, "write_3f8");
    check_read(10'h3FF, "alias_3ff");
    @(negedge clk);
    check_read(10'h3F0, "neighbour_3f0");

    do_write(10'h040, 64'h11111111_22222222);
    do_write(10'h044, 64'h33333333_44444444);
    check_read(10'h040, "last_write_wins_040");
    @(negedge clk);
    check_read(10'h047, "last_write_wins_047");

    // Read during write on the same block: old value before the edge, new after.
    @(negedge clk);
    mem_write      = 1'b1;
    mem_address    = 10'h010;
    mem_write_data = 64'hAAAA_AAAA_5555_5555;
    check_read(10'h010, "rdw_before_edge");
    @(posedge clk);
    ref_mem[10'h010 / 8] = 64'hAAAA_AAAA_5555_5555;
    #1;
    check_read(10'h010, "rdw_after_edge");
    @(negedge clk);
    mem_write = 1'b0;

    for (int n = 0; n < 40; n++) begin
      do_write(10'($urandom_range(0, 1023)), {$urandom, $urandom});
    end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      check_read(10'($urandom_range(0, 1023)), "random_read");
    end

    // Asynchronous reset mid-cycle must take effect without a clock edge.
    do_write(10'h100, 64'h0000_0000_0000_1234);
    check_read(10'h100, "pre_reset_100");
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    check_read(10'h100, "async_reset_100");
    @(negedge clk);
    check_read(10'h3F8, "async_reset_3f8");

    // Write coincident with reset is lost.
    @(negedge clk);
    mem_write      = 1'b1;
    mem_address    = 10'h080;
    mem_write_data = '1;
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    rst       = 1'b0;
    check_read(10'h080, "write_during_reset_080");
    @(negedge clk);
    check_read(10'h100, "post_reset_100");

    do_write(10'h080, 64'h0123_4567_89AB_CDEF);
    check_read(10'h087, "write_after_reset_080");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_memory_bank.md
Name: main_memory_bank

Overview:
- Backing store behind the two-way data cache: 1024 bytes organised as 128 blocks of 64 bits (two 32-bit words per block).
- The cache writes back a dirty 64-bit block and fetches a 64-bit block on a miss.
- Read is combinational; write is synchronous on the clock.

Parameters:
- ADDR_W, 10, byte-address width (1024 bytes).
- DATA_W, 64, block width in bits; fixed at 64 (two 32-bit words).
- DEPTH, 2**(ADDR_W-3), number of 8-byte blocks (128). Derived; do not override.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- mem_write  input  1  write enable; when high, the block is written at the next rising clk.
- mem_address  input  ADDR_W  byte address. Block index is mem_address[9:3]; bits [2:0] are ignored.
- mem_write_data  input  DATA_W  block to store. [63:32] is word 1 (address bit 2 = 1); [31:0] is word 0.
- mem_read_data  output  DATA_W  contents of the block selected by mem_address[9:3].

Behaviour:
- Storage: array of DEPTH x 64-bit entries, indexed by mem_address[9:3].
- Read path:
  - mem_read_data = mem[mem_address[9:3]], purely combinational.
  - Zero-cycle latency: it follows mem_address within the same delta/cycle.
  - No read enable.
- Write path:
  - On posedge clk with rst low and mem_write high: mem[mem_address[9:3]] <= mem_write_data.
  - All 64 bits are written; no byte enables.
  - Low address bits [2:0] do not affect which block is written. Addresses 0x008 and 0x00F hit the same block.
- Read-during-write to the same block: mem_read_data shows the old contents until the rising edge, then the new contents immediately after. There is no bypass.
- Reset:
  - While rst is high, every entry is asynchronously forced to its reset value. With MEM_INIT_PATTERN_EN undefined, that value is 0.
  - Writes are ignored while rst is high.
  - mem_read_data therefore reads the reset value of the addressed block during and after reset.
  - Reset asserted mid-write (same cycle as a mem_write edge): reset wins and the write is lost.
- X handling: mem_write = X is treated as no write. A bench assertion flags an X on mem_write outside reset.
- Wrap-around: none. The full 10-bit address space maps one-to-one onto 128 blocks.
- No state machine; no handshake. The cache sequences write-back (address/data/write) and then fetch (address) itself.

Optional Feature:
- Macro: MEM_INIT_PATTERN_EN.
- Defined: the reset value of block b is {32'(2*b+1), 32'(2*b)}, i.e. each 32-bit word holds its own word index (byte address >> 2). Block 5 therefore resets to 0x0000000B_0000000A.
- Undefined: every block resets to 64'h0.
- Behaviour outside reset is identical in both cases.

Decomposition:
- Package main_memory_pkg holds:
  - ADDR_W, DATA_W, BLOCK_OFS_W = 3, DEPTH, WORD_W = 32.
  - A function init_block(index) returning the reset pattern, shared with the cache bench.
- No sub-module: the array, async reset and combinational read are implemented inline in main_memory_bank.

Test Plan:
- Assert rst, release; read mem_address 0x028 (block 5) -> mem_read_data = 0 (macro off) or 0x0000000B_0000000A (macro on).
- mem_write=1, mem_address=0x3F8, mem_write_data=0xDEADBEEF_CAFEF00D, one clk edge, then mem_write=0 -> reading 0x3F8 and 0x3FF both return 0xDEADBEEF_CAFEF00D; block 126 (0x3F0) is unchanged.
- Write 0x11111111_22222222 to 0x040, then write 0x33333333_44444444 to 0x044 -> reading 0x040 returns 0x33333333_44444444 (same block, last write wins).
- With mem_address fixed at 0x010 and mem_write high, mem_write_data=0xAAAA_AAAA_5555_5555 -> before the edge mem_read_data shows the old value; after the edge it shows the new value.
- Write 0x1234 to 0x100, then pulse rst asynchronously mid-cycle -> mem_read_data at 0x100 returns the reset value immediately, without waiting for a clk edge.
- rst high together with mem_write=1, address 0x080, data 0xFFFF... at a clk edge -> after reset, block 16 holds its reset value.
